wr_sl_arbiter: RTL and testbench

Per-slave write-channel arbiter for the two-master AXI interconnect. It picks which master owns one slave's write path and holds that ownership across the AW, W and B phases. Its registered `mas_sel` output drives the address/data forward muxes and the write-response return mux. One instance sits in front of each slave, directly upstream of the write-response return path.

---
 rtl/axi_ic_pkg.sv | 18 +
 rtl/rr_pick2.sv | 23 ++
 rtl/wr_sl_arbiter.sv | 124 ++++++++++++
 tb/tb_wr_sl_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/axi_ic_pkg.sv
// Shared definitions for the two-master AXI interconnect: write-arbiter states,
// owner select codes and the default burst-length width.
package axi_ic_pkg;

  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_state_e;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_M1   = 2'b01;
  localparam logic [1:0] SEL_M2   = 2'b10;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin pick. token = 0 gives master 1 priority on a tie;
// next_token points away from whoever was granted.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       token,
  output logic [1:0] grant,
  output logic       next_token
);

  always_comb begin
    grant      = 2'b00;
    next_token = token;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = token ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    if (grant[0])      next_token = 1'b1;
    else if (grant[1]) next_token = 1'b0;
  end

endmodule

// File: rtl/wr_sl_arbiter.sv
// Per-slave write-channel arbiter: grants one master the AW/W/B path of this
// slave and holds ownership until the write response is accepted.
module wr_sl_arbiter
  import axi_ic_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             m1_req,
  input  logic             m2_req,
  input  logic [LEN_W-1:0] m1_AWLEN,
  input  logic [LEN_W-1:0] m2_AWLEN,
  input  logic             m1_WVALID,
  input  logic             m2_WVALID,
  input  logic             m1_WLAST,
  input  logic             m2_WLAST,
  input  logic             m1_BREADY,
  input  logic             m2_BREADY,
  input  logic             s_AWREADY,
  input  logic             s_WREADY,
  input  logic             s_BVALID,
  output logic [1:0]       mas_sel,
  output logic             busy,
  output logic             len_err
);

  wr_state_e        state_q, state_d;
  logic [1:0]       mas_sel_q, mas_sel_d;
  logic             busy_q, busy_d;
  logic             len_err_q, len_err_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             token_q, token_d;

  logic             g_req, g_wvalid, g_wlast, g_bready;
  logic [LEN_W-1:0] g_awlen;
  logic [1:0]       pick_req, pick_grant;
  logic             pick_next;

  // Owner's channel signals; only meaningful once a grant is held.
  assign g_req    = mas_sel_q[1] ? m2_req    : m1_req;
  assign g_awlen  = mas_sel_q[1] ? m2_AWLEN  : m1_AWLEN;
  assign g_wvalid = mas_sel_q[1] ? m2_WVALID : m1_WVALID;
  assign g_wlast  = mas_sel_q[1] ? m2_WLAST  : m1_WLAST;
  assign g_bready = mas_sel_q[1] ? m2_BREADY : m1_BREADY;

  // Outside IDLE the picker sees only the owner, so its next_token is the
  // token rotation applied when the response completes.
  assign pick_req = (state_q == IDLE) ? {m2_req, m1_req} : mas_sel_q;

  rr_pick2 u_pick (
    .req        (pick_req),
    .token      (token_q),
    .grant      (pick_grant),
    .next_token (pick_next)
  );

  always_comb begin
    state_d    = state_q;
    mas_sel_d  = mas_sel_q;
    beat_cnt_d = beat_cnt_q;
    token_d    = token_q;
    len_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_grant != 2'b00) begin
          mas_sel_d = pick_grant;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (g_req && s_AWREADY) begin
          beat_cnt_d = g_awlen;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (g_wvalid && s_WREADY) begin
          if (g_wlast) begin
            state_d   = RESP;
            len_err_d = (beat_cnt_q != '0);
          end else if (beat_cnt_q == '0) begin
            // Too many beats: flag it, stay put until WLAST shows up.
            len_err_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q - LEN_W'(1);
          end
        end
      end
      RESP: begin
        if (s_BVALID && g_bready) begin
          state_d   = IDLE;
          mas_sel_d = SEL_NONE;
          token_d   = pick_next;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      mas_sel_q  <= SEL_NONE;
      busy_q     <= 1'b0;
      len_err_q  <= 1'b0;
      beat_cnt_q <= '0;
      token_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mas_sel_q  <= mas_sel_d;
      busy_q     <= busy_d;
      len_err_q  <= len_err_d;
      beat_cnt_q <= beat_cnt_d;
      token_q    <= token_d;
    end
  end

  assign mas_sel = mas_sel_q;
  assign busy    = busy_q;
  assign len_err = len_err_q;

endmodule

// File: tb/tb_wr_sl_arbiter.sv
// Directed bench for wr_sl_arbiter: each step queues the expected outputs,
// which are popped and compared one time unit after the clock edge.
module tb_wr_sl_arbiter;

  localparam int LEN_W = 8;

  logic             ACLK = 1'b0;
  logic             ARESETn;
  logic             m1_req, m2_req;
  logic [LEN_W-1:0] m1_AWLEN, m2_AWLEN;
  logic             m1_WVALID, m2_WVALID, m1_WLAST, m2_WLAST;
  logic             m1_BREADY, m2_BREADY;
  logic             s_AWREADY, s_WREADY, s_BVALID;
  logic [1:0]       mas_sel;
  logic             busy, len_err;

  typedef struct packed {
    logic [1:0] sel;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 ACLK = ~ACLK;

  wr_sl_arbiter #(.LEN_W(LEN_W)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .m1_req    (m1_req),
    .m2_req    (m2_req),
    .m1_AWLEN  (m1_AWLEN),
    .m2_AWLEN  (m2_AWLEN),
    .m1_WVALID (m1_WVALID),
    .m2_WVALID (m2_WVALID),
    .m1_WLAST  (m1_WLAST),
    .m2_WLAST  (m2_WLAST),
    .m1_BREADY (m1_BREADY),
    .m2_BREADY (m2_BREADY),
    .s_AWREADY (s_AWREADY),
    .s_WREADY  (s_WREADY),
    .s_BVALID  (s_BVALID),
    .mas_sel   (mas_sel),
    .busy      (busy),
    .len_err   (len_err)
  );

  task automatic check(input string tag);
    exp_t x;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    x = exp_q.pop_front();
    total += 3;
    assert (mas_sel === x.sel) else begin
      bad++;
      $error("FAIL %s mas_sel: got %b want %b", tag, mas_sel, x.sel);
    end
    assert (busy === x.busy) else begin
      bad++;
      $error("FAIL %s busy: got %b want %b", tag, busy, x.busy);
    end
    assert (len_err === x.err) else begin
      bad++;
      $error("FAIL %s len_err: got %b want %b", tag, len_err, x.err);
    end
  endtask

  // Expectation for the outputs after the next rising edge.
  task automatic step(input string tag, input logic [1:0] s, input logic b, input logic e);
    exp_q.push_back('{sel: s, busy: b, err: e});
    @(posedge ACLK);
    #1;
    check(tag);
  endtask

  task automatic chk_now(input string tag, input logic [1:0] s, input logic b, input logic e);
    exp_q.push_back('{sel: s, busy: b, err: e});
    check(tag);
  endtask

  task automatic clear_in();
    m1_req = 0; m2_req = 0; m1_AWLEN = '0; m2_AWLEN = '0;
    m1_WVALID = 0; m2_WVALID = 0; m1_WLAST = 0; m2_WLAST = 0;
    m1_BREADY = 0; m2_BREADY = 0;
    s_AWREADY = 0; s_WREADY = 0; s_BVALID = 0;
  endtask

  initial begin
    clear_in();
    ARESETn = 1'b0;
    m1_req = 1; m2_req = 1;
    #12;
    chk_now("in_reset", 2'b00, 0, 0);
    ARESETn = 1'b1;

    // Tie after reset goes to master 1; then a clean 4-beat M1 burst.
    m1_AWLEN = 8'd3; s_AWREADY = 1;
    step("rst_grant", 2'b01, 1, 0);
    m2_req = 0;
    step("m1_aw", 2'b01, 1, 0);
    m1_req = 0; s_AWREADY = 0; m1_WVALID = 1; s_WREADY = 1;
    for (int i = 0; i < 3; i++) step("m1_beat", 2'b01, 1, 0);
    m1_WLAST = 1;
    step("m1_last", 2'b01, 1, 0);
    clear_in(); s_BVALID = 1; m1_BREADY = 1;
    step("m1_b", 2'b00, 0, 0);
    clear_in();

    // Continuous requests from both: token now favours M2, then alternates.
    m1_req = 1; m2_req = 1; s_AWREADY = 1; s_WREADY = 1;
    m1_WVALID = 1; m2_WVALID = 1; m1_WLAST = 1; m2_WLAST = 1;
    s_BVALID = 1; m1_BREADY = 1; m2_BREADY = 1;
    for (int k = 0; k < 4; k++) begin
      step("alt_grant", (k % 2 == 0) ? 2'b10 : 2'b01, 1, 0);
      step("alt_aw",    (k % 2 == 0) ? 2'b10 : 2'b01, 1, 0);
      step("alt_w",     (k % 2 == 0) ? 2'b10 : 2'b01, 1, 0);
      step("alt_b_idle", 2'b00, 0, 0);
    end
    clear_in();

    // M2 AWLEN=1, WLAST on the first beat: short burst.
    m2_req = 1; m2_AWLEN = 8'd1; s_AWREADY = 1;
    step("short_grant", 2'b10, 1, 0);
    step("short_aw", 2'b10, 1, 0);
    m2_req = 0; s_AWREADY = 0; m2_WVALID = 1; m2_WLAST = 1; s_WREADY = 1;
    step("short_err", 2'b10, 1, 1);
    m2_WVALID = 0; m2_WLAST = 0;
    step("short_resp", 2'b10, 1, 0);
    s_BVALID = 1; m2_BREADY = 1;
    step("short_b", 2'b00, 0, 0);
    clear_in();

    // M2 AWLEN=1, WLAST on the third beat: long burst.
    m2_req = 1; m2_AWLEN = 8'd1; s_AWREADY = 1;
    step("long_grant", 2'b10, 1, 0);
    step("long_aw", 2'b10, 1, 0);
    m2_req = 0; s_AWREADY = 0; m2_WVALID = 1; s_WREADY = 1;
    step("long_beat1", 2'b10, 1, 0);
    step("long_beat2", 2'b10, 1, 1);
    m2_WLAST = 1;
    step("long_beat3", 2'b10, 1, 0);
    m2_WVALID = 0; m2_WLAST = 0;
    step("long_resp", 2'b10, 1, 0);
    s_BVALID = 1; m2_BREADY = 1;
    step("long_b", 2'b00, 0, 0);
    clear_in();

    // Quick M1 transaction so the token points at M2 before the reset test.
    m1_req = 1; s_AWREADY = 1;
    step("q_grant", 2'b01, 1, 0);
    step("q_aw", 2'b01, 1, 0);
    m1_req = 0; m1_WVALID = 1; m1_WLAST = 1; s_WREADY = 1;
    step("q_w", 2'b01, 1, 0);
    clear_in(); s_BVALID = 1; m1_BREADY = 1;
    step("q_b", 2'b00, 0, 0);
    clear_in();

    // M1 AWLEN=7, two beats in (beat_cnt = 5), then reset.
    m1_req = 1; m1_AWLEN = 8'd7; s_AWREADY = 1;
    step("r_grant", 2'b01, 1, 0);
    step("r_aw", 2'b01, 1, 0);
    m1_req = 0; s_AWREADY = 0; m1_WVALID = 1; s_WREADY = 1;
    step("r_beat1", 2'b01, 1, 0);
    step("r_beat2", 2'b01, 1, 0);
    ARESETn = 1'b0;
    #1;
    chk_now("mid_reset", 2'b00, 0, 0);
    clear_in();
    m1_req = 1; m2_req = 1;
    #1;
    ARESETn = 1'b1;
    step("post_rst_grant", 2'b01, 1, 0);

    // M1 held in RESP by BREADY low while M2 keeps requesting.
    m1_AWLEN = 8'd0; s_AWREADY = 1;
    step("st_aw", 2'b01, 1, 0);
    m1_req = 0; s_AWREADY = 0; m1_WVALID = 1; m1_WLAST = 1; s_WREADY = 1;
    step("st_w", 2'b01, 1, 0);
    m1_WVALID = 0; m1_WLAST = 0; s_BVALID = 1;
    for (int i = 0; i < 4; i++) step("st_hold", 2'b01, 1, 0);
    m1_BREADY = 1;
    step("st_b", 2'b00, 0, 0);
    m1_BREADY = 0; s_BVALID = 0;
    step("st_m2_grant", 2'b10, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
